// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode/rename.
// Circular FIFO of {pc, inst} pairs with a valid/ready handshake on both sides.
// A backend flush empties the queue. Entry storage is not reset.
module inst_queue #(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [31:0]      enq_pc,
    input  logic [31:0]      enq_inst,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [31:0]      deq_pc,
    output logic [31:0]      deq_inst,
    output logic [PTR_W:0]   count
);

    logic [63:0]      mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             full;
    logic             empty;
    logic             enq_fire;
    logic             deq_fire;

    assign wr_idx = wr_ptr[PTR_W-1:0];
    assign rd_idx = rd_ptr[PTR_W-1:0];

    // The pointer MSB is a wrap bit: equal indices mean full when the wrap bits differ.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_idx == rd_idx) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign enq_fire  = enq_valid && !full;
    assign deq_fire  = deq_ready && !empty;
    assign count     = wr_ptr - rd_ptr;

    // Pointer update; flush takes priority over any handshake in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry write on an accepted enqueue; storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (enq_fire && !flush) mem[wr_idx] <= {enq_pc, enq_inst};
    end

    // Head entry presentation, zeroed when empty so decode sees an invalid instruction.
    always_comb begin
        deq_pc   = '0;
        deq_inst = '0;
        if (!empty) {deq_pc, deq_inst} = mem[rd_idx];
    end

    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        (full && !flush) |=> (wr_ptr == $past(wr_ptr)));

    a_no_deq_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        (empty && !flush) |=> (rd_ptr == $past(rd_ptr)));

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (int'(count) <= DEPTH));

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    logic [31:0]      enq_pc;
    logic [31:0]      enq_inst;
    logic             deq_valid;
    logic             deq_ready;
    logic [31:0]      deq_pc;
    logic [31:0]      deq_inst;
    logic [PTR_W:0]   count;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;
    int unsigned seg_enq      = 0;
    int unsigned wraps        = 0;

    logic [63:0] q [$];

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_pc    (enq_pc),
        .enq_inst  (enq_inst),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_pc    (deq_pc),
        .deq_inst  (deq_inst),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Compare every output against the reference queue.
    task automatic check_outputs(input string tag);
        logic [63:0] head;
        head = (q.size() > 0) ? q[0] : 64'h0;
        check({tag, "_enq_ready"}, 64'(enq_ready), 64'(q.size() < DEPTH));
        check({tag, "_deq_valid"}, 64'(deq_valid), 64'(q.size() > 0));
        check({tag, "_deq_pc"},    64'(deq_pc),    64'(head[63:32]));
        check({tag, "_deq_inst"},  64'(deq_inst),  64'(head[31:0]));
        check({tag, "_count"},     64'(count),     64'(q.size()));
    endtask

    // One clock cycle: drive inputs just after a falling edge, check that outputs do not
    // react combinationally to them, advance the model at the rising edge, recheck.
    task automatic cycle(input logic ev, input logic [31:0] pc, input logic [31:0] inst,
                         input logic dr, input logic fl);
        bit ef;
        bit df;
        enq_valid = ev;
        enq_pc    = pc;
        enq_inst  = inst;
        deq_ready = dr;
        flush     = fl;
        ef = ev && (q.size() < DEPTH);
        df = dr && (q.size() > 0);
        #1;
        check_outputs("pre");
        @(posedge clk);
        if (fl) begin
            q.delete();
            seg_enq = 0;
        end else begin
            if (df) void'(q.pop_front());
            if (ef) begin
                q.push_back({pc, inst});
                seg_enq++;
                if (seg_enq == 2 * DEPTH) begin
                    wraps++;
                    seg_enq = 0;
                end
            end
        end
        @(negedge clk);
        check_outputs("post");
    endtask

    // Asynchronous reset in the middle of a cycle with busy-looking inputs.
    task automatic do_reset();
        enq_valid = 1'b1;
        deq_ready = 1'b1;
        flush     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_enq_ready", 64'(enq_ready), 64'h1);
        check("rst_deq_valid", 64'(deq_valid), 64'h0);
        check("rst_deq_pc",    64'(deq_pc),    64'h0);
        check("rst_deq_inst",  64'(deq_inst),  64'h0);
        check("rst_count",     64'(count),     64'h0);
        q.delete();
        seg_enq = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check("after_rst_enq_ready", 64'(enq_ready), 64'h1);
        check("after_rst_count",     64'(count),     64'h0);
    endtask

    initial begin
        int ev_pct;
        int dr_pct;
        rst_n     = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_pc    = '0;
        enq_inst  = '0;
        deq_ready = 1'b0;

        // Reset then idle
        #12;
        check("reset_enq_ready", 64'(enq_ready), 64'h1);
        check("reset_deq_valid", 64'(deq_valid), 64'h0);
        check("reset_count",     64'(count),     64'h0);
        check("reset_deq_inst",  64'(deq_inst),  64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Single entry visible the cycle after enqueue
        cycle(1'b1, 32'h6000_0000, 32'h0000_0513, 1'b0, 1'b0);
        check("single_valid", 64'(deq_valid), 64'h1);
        check("single_pc",    64'(deq_pc),    64'h6000_0000);
        check("single_inst",  64'(deq_inst),  64'h0000_0513);
        check("single_count", 64'(count),     64'h1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Fill to DEPTH, reject a 17th, drain in order
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'h6000_0000 + 32'(4 * i), 32'h0010_0013 + 32'(i), 1'b0, 1'b0);
        check("fill_count", 64'(count),     64'(DEPTH));
        check("fill_ready", 64'(enq_ready), 64'h0);
        cycle(1'b1, 32'h6000_0040, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("fill_17th_count", 64'(count), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_pc", 64'(deq_pc), 64'(32'h6000_0000 + 32'(4 * i)));
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        check("drain_count", 64'(count),     64'h0);
        check("drain_valid", 64'(deq_valid), 64'h0);

        // Full with simultaneous enqueue and dequeue: only the dequeue fires
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'h6000_0100 + 32'(4 * i), 32'h0020_0013 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h6000_0200, 32'h0000_0073, 1'b1, 1'b0);
        check("full_both_count", 64'(count),     64'(DEPTH - 1));
        check("full_both_ready", 64'(enq_ready), 64'h1);
        cycle(1'b1, 32'h6000_0200, 32'h0000_0073, 1'b0, 1'b0);
        check("full_held_count", 64'(count), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush mid-stream drops the same-cycle enqueue and dequeue
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h6000_0300 + 32'(4 * i), 32'h0030_0013, 1'b0, 1'b0);
        cycle(1'b1, 32'h6000_0500, 32'h0040_0013, 1'b1, 1'b1);
        check("flush_count", 64'(count),     64'h0);
        check("flush_valid", 64'(deq_valid), 64'h0);
        cycle(1'b1, 32'h6000_1000, 32'h0050_0013, 1'b0, 1'b0);
        check("flush_new_head", 64'(deq_pc), 64'h6000_1000);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic with phases biased toward full and toward empty
        seg_enq = 0;
        wraps   = 0;
        for (int c = 0; c < 1000; c++) begin
            if (c == 250 || c == 500 || c == 750) do_reset();
            ev_pct = ((c / 100) % 2 == 1) ? 80 : 30;
            dr_pct = ((c / 100) % 2 == 1) ? 30 : 80;
            cycle(1'($urandom_range(0, 99) < ev_pct), $urandom, $urandom,
                  1'($urandom_range(0, 99) < dr_pct), 1'($urandom_range(0, 99) == 0));
        end
        check("pointer_wraps", 64'(wraps >= 2), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
